// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-RAM burst slave: command encodings and FSM states.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM, DATA_WIDTH x 2**ADDR_WIDTH, synchronous write and registered
// read (read-before-write). Contents are never cleared.
module spi_ram_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write when enabled; always register the addressed word for reading.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave in front of a single-port RAM. Frames: 2 command bits then payload,
// MSB first, while SS_n is low. Optional macro BURST_EN enables auto-increment
// bursts on write-data and read-data frames; without it each frame moves one word.
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int SR_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0]      AW_LAST  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DW_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DW_END   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [SR_W-1:0]       r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_miso;

  logic                  w_we;
  logic                  w_rd_wrap;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // The write fires on the edge that samples the last data bit, so the word is
  // assembled from the shift register plus the bit currently on MOSI.
  assign w_we      = !SS_n && (r_state == ST_WR_DATA) && (r_cnt == DW_LAST);
  assign w_wdata   = {r_shift[DATA_WIDTH-2:0], MOSI};
  assign w_rd_wrap = (r_state == ST_RD_DATA) && (r_cnt == DW_END);

  // RAM address: write address during a write, otherwise the read address.
  // In a read burst the incremented address is presented on the turnaround edge
  // so the registered read output is ready for the following RD_LOAD.
  always_comb begin
    w_ram_addr = r_rd_addr;
    if (w_we)
      w_ram_addr = r_wr_addr;
`ifdef BURST_EN
    else if (!SS_n && w_rd_wrap)
      w_ram_addr = r_rd_addr + ADDR_ONE;
`endif
  end

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Frame FSM: command decode, payload shifting, address updates and MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_miso    <= 1'b0;
    end else if (SS_n) begin
      // Frame ended or not started: any partial word is dropped.
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
    end else begin
      r_miso <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_shift <= {r_shift[SR_W-2:0], MOSI};
          r_state <= ST_CMD;
        end
        ST_CMD: begin
          r_shift <= '0;
          r_cnt   <= '0;
          case ({r_shift[0], MOSI})
            CMD_WR_ADDR: r_state <= ST_WR_ADDR;
            CMD_WR_DATA: r_state <= ST_WR_DATA;
            CMD_RD_ADDR: r_state <= ST_RD_ADDR;
            default:     r_state <= ST_RD_LOAD;
          endcase
        end
        ST_WR_ADDR: begin
          r_shift <= {r_shift[SR_W-2:0], MOSI};
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == AW_LAST) begin
            r_wr_addr <= {r_shift[ADDR_WIDTH-2:0], MOSI};
            r_state   <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          r_shift <= {r_shift[SR_W-2:0], MOSI};
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == AW_LAST) begin
            r_rd_addr <= {r_shift[ADDR_WIDTH-2:0], MOSI};
            r_state   <= ST_DONE;
          end
        end
        ST_WR_DATA: begin
          r_shift <= {r_shift[SR_W-2:0], MOSI};
          if (r_cnt == DW_LAST) begin
            r_cnt <= '0;
`ifdef BURST_EN
            r_wr_addr <= r_wr_addr + ADDR_ONE;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RD_LOAD: begin
          r_shift <= SR_W'(w_rdata);
          r_cnt   <= '0;
          r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (!w_rd_wrap) begin
            r_miso  <= r_shift[DATA_WIDTH-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CNT_ONE;
          end else begin
            r_cnt <= '0;
`ifdef BURST_EN
            r_rd_addr <= r_rd_addr + ADDR_ONE;
            r_state   <= ST_RD_LOAD;
`else
            r_state <= ST_DONE;
`endif
          end
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

  assign MISO = r_miso;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Scoreboard bench for spi_ram_burst_slave: stimulus pushes the expected MISO
// value for every clock edge; a monitor pops and compares after each edge.
// Burst or single-word expectations follow the BURST_EN macro.
module tb_spi_ram_burst_slave;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  spi_ram_burst_slave #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  v;
    int    en;
    string name;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string cur   = "reset";

  task automatic push(input logic v, input int en);
    exp_t x;
    x.v = v;
    x.en = en;
    x.name = cur;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      push(1'b0, 0);
    end
  endtask

  // One frame of ncyc clocks with SS_n low, then one clock with SS_n high.
  // For read-data frames rw holds up to two expected words (rw[15:8] first);
  // each word occupies 8 bit-edges plus 2 zero edges (turnaround + reload).
  task automatic frame(input logic [1:0] cmd, input logic [31:0] pay, input int npay,
                       input int ncyc, input logic [15:0] rw, input int nrw);
    for (int e = 1; e <= ncyc; e++) begin
      logic b;
      logic x;
      int   rel;
      int   pos;
      int   wi;
      @(negedge clk);
      SS_n = 1'b0;
      if (e == 1)            b = cmd[1];
      else if (e == 2)       b = cmd[0];
      else if (e - 3 < npay) b = pay[npay - 1 - (e - 3)];
      else                   b = 1'b0;
      MOSI = b;
      x = 1'b0;
      if (cmd == 2'b11 && e >= 4) begin
        rel = e - 4;
        pos = rel % 10;
        wi  = rel / 10;
        if (pos < 8 && wi < nrw) x = (wi == 0) ? rw[15 - pos] : rw[7 - pos];
      end
      push(x, e);
    end
    idle(1);
  endtask

  task automatic wa(input logic [7:0] a);
    frame(2'b00, {24'h0, a}, 8, 10, 16'h0, 0);
  endtask
  task automatic wd(input logic [7:0] d);
    frame(2'b01, {24'h0, d}, 8, 10, 16'h0, 0);
  endtask
  task automatic ra(input logic [7:0] a);
    frame(2'b10, {24'h0, a}, 8, 10, 16'h0, 0);
  endtask
  task automatic rd1(input logic [7:0] w);
    frame(2'b11, 32'h0, 0, 12, {w, 8'h00}, 1);
  endtask

  // Monitor: compare MISO against the scoreboard shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        n_vec++;
        if (MISO !== x.v) begin
          n_bad++;
          $display("FAIL %s E%0d: MISO=%b expected %b", x.name, x.en, MISO, x.v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cur = "reset";
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      push(1'b0, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 0);
    idle(2);

    cur = "wr_then_rd_2A";
    wa(8'h2A);
    wd(8'hFF);
    ra(8'h2A);
    rd1(8'hFF);

`ifdef BURST_EN
    cur = "burst_wr_wrap";
    wa(8'hFE);
    frame(2'b01, 32'h00112233, 24, 26, 16'h0, 0);
    wd(8'h44);
    cur = "burst_rd_FE";
    ra(8'hFE);
    frame(2'b11, 32'h0, 0, 22, 16'h1122, 2);
    cur = "burst_rd_00";
    ra(8'h00);
    frame(2'b11, 32'h0, 0, 22, 16'h3344, 2);
`else
    cur = "single_wr";
    wa(8'h11);
    wd(8'h00);
    wa(8'h10);
    frame(2'b01, 32'h00005AC3, 16, 18, 16'h0, 0);
    ra(8'h10);
    rd1(8'h5A);
    cur = "single_no_spill";
    ra(8'h11);
    rd1(8'h00);
    cur = "single_wr_addr_kept";
    wd(8'h66);
    ra(8'h10);
    frame(2'b11, 32'h0, 0, 19, 16'h6600, 1);
    cur = "single_rd_addr_kept";
    rd1(8'h66);
`endif

    cur = "abort";
    wa(8'h2A);
    frame(2'b01, 32'hA, 4, 6, 16'h0, 0);
    frame(2'b00, 32'h5, 4, 6, 16'h0, 0);
    ra(8'h2A);
    rd1(8'hFF);
    wd(8'h3C);
    ra(8'h2A);
    rd1(8'h3C);

    cur = "reset_mid_read";
    ra(8'h2A);
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = (e <= 2) ? 1'b1 : 1'b0;
      push((e == 6) ? 1'b1 : 1'b0, e);
    end
    @(negedge clk);
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    push(1'b0, 0);
    #1;
    n_vec++;
    if (MISO !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: MISO=%b expected 0", MISO);
    end
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 0);

    cur = "after_reset_addr0";
    wd(8'hC5);
    rd1(8'hC5);
    idle(2);

    repeat (4) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI slave with a single-port RAM, next generation of the team's SPI-RAM slave. Commands and payloads are shifted in MSB-first on MOSI while SS_n is low. Read data is shifted out on MISO. Address and data widths are configurable, and write/read-data frames support auto-increment bursts. Sits between the external SPI pins and the on-chip RAM store.

## Interface
- ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, RAM word width
- clk  input  1  system clock; all sampling and updates on rising edge
- rst  input  1  asynchronous, active-high reset
- SS_n  input  1  active-low frame select
- MOSI  input  1  serial command/payload, MSB first
- MISO  output  1  serial read data, MSB first, registered

## Operation
- Frame: SS_n low, 2 command bits, then payload. Command encodings:
  - 00 = write address: payload ADDR_WIDTH bits, loads wr_addr.
  - 01 = write data: payload DATA_WIDTH bits, writes mem[wr_addr].
  - 10 = read address: payload ADDR_WIDTH bits, loads rd_addr.
  - 11 = read data: MISO drives mem[rd_addr].
- States: IDLE, CMD (2 bits), WR_ADDR, WR_DATA, RD_ADDR, RD_LOAD, RD_DATA, DONE.
- IDLE -> CMD on the first edge with SS_n low; that edge samples command bit 1.
- Any state -> IDLE on any edge with SS_n high. A partial word is discarded: no write, no address change.
- WR_ADDR / RD_ADDR -> DONE after the last address bit. DONE holds until SS_n is high.
- Address increments wrap modulo 2**ADDR_WIDTH.
- wr_addr and rd_addr are independent registers. Both reset to 0.
- Read-data without a prior read-address reads mem[rd_addr] as it stands.
- RAM contents are not cleared by rst.
- rst mid-frame: state IDLE, MISO 0, shift counters 0, no write.

## Timing
- Reset values:
  - Outputs: MISO 0.
  - Internal: state IDLE, wr_addr 0, rd_addr 0, shift register 0, bit counter 0.
- Edge numbering: E1/E2 sample command bits; payload bit k (MSB = 0) is sampled at E3+k.
- Write data: the word is written to RAM on the same edge that samples its last bit (E2+DATA_WIDTH).
- Read data:
  - E3 (RD_LOAD): shift register <= mem[rd_addr].
  - E4..E3+DATA_WIDTH: MISO <= shift register MSB, then shift left.
  - MISO returns to 0 on the edge after the last bit, and in every state other than RD_DATA.
- Timing when BURST_EN is not defined (single-word frames) is given under Configuration.

## Configuration
- BURST_EN defined:
  - WR_DATA: after each completed word, wr_addr increments. The next DATA_WIDTH bits follow with no gap.
  - RD_DATA: after the last bit of each word, rd_addr increments and the state returns to RD_LOAD. This gives one MISO=0 turnaround cycle per word, then the next word.
  - Bursts continue until SS_n goes high.
- BURST_EN undefined:
  - A single word per frame, then DONE. Extra bits are ignored.
  - wr_addr and rd_addr never auto-increment.

## Structure
- Package spi_ram_pkg holds:
  - command encodings CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA;
  - the state enum type.
- Sub-module spi_ram_mem: single-port RAM, DATA_WIDTH x 2**ADDR_WIDTH, synchronous write, registered read, write-enable and address inputs.
- The top level holds the FSM, shift registers, bit counter and address registers.

## Test plan
All scenarios use defaults 8/8 with BURST_EN defined unless stated.
- Write address then write data:
  - Frame 00 + 0x2A, SS_n high, then frame 01 + 0xFF -> mem[0x2A] = 0xFF.
  - Frame 10 + 0x2A, then frame 11 -> MISO 1,1,1,1,1,1,1,1 on E4..E11; MISO 0 otherwise.
- Burst write wrap:
  - wr_addr 0xFE, frame 01 + 0x11, 0x22, 0x33 -> mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33.
  - wr_addr ends at 0x01.
- Burst read:
  - rd_addr 0xFE, frame 11 held for 2 words -> MISO 0x11 on E4..E11, 0 at E12, E13 reload, 0x22 on E14..E21.
- Abort and reset:
  - SS_n high after 4 data bits of a write -> target word unchanged, wr_addr unchanged.
  - rst pulsed mid-read -> MISO 0 immediately, next frame decodes from IDLE.
- BURST_EN undefined:
  - Frame 01 + 0x5A + 0xC3 -> only mem[wr_addr] = 0x5A, wr_addr unchanged.
  - Frame 11 with 16 clocks -> one word then MISO 0.
